// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory controller: default widths and FSM states.
// Optional build macro DM_INIT_EN adds the INIT state that zero-fills memory after reset.
package dm_ctrl_pkg;

    localparam int unsigned DM_INSTR_WORD_WIDTH = 8;
    localparam int unsigned DM_DATA_WIDTH       = 8;

`ifdef DM_INIT_EN
    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_ACCESS,
        S_RESP
    } dm_state_e;

    localparam dm_state_e DM_RESET_STATE = S_INIT;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } dm_state_e;

    localparam dm_state_e DM_RESET_STATE = S_IDLE;
`endif

endpackage

// File: rtl/dm_ctrl.sv
// Data-memory controller: accepts one load/store at a time from the core,
// performs a single-cycle memory access and holds the response until consumed.
// Build macro DM_INIT_EN: after reset, walk every address writing zero before going idle.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DM_INSTR_WORD_WIDTH,
    parameter int unsigned DATA_WIDTH    = DM_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wr,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     busy,
    output logic                     mem_wr,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    dm_state_e                state_q;
    dm_state_e                state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     wr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
`ifdef DM_INIT_EN
    logic [ADDRESS_WIDTH-1:0] init_cnt_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DM_RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode from state and the registered request fields.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
`ifdef DM_INIT_EN
            S_INIT: begin
                // Gated by rst_n so a held reset never strobes the memory.
                mem_wr   = rst_n;
                mem_addr = init_cnt_q;
                if (init_cnt_q == '1) begin
                    state_d = S_IDLE;
                end
            end
`endif
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_wr    = wr_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = DM_RESET_STATE;
            end
        endcase
    end

    // Request capture, load-data capture and the init address walker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef DM_INIT_EN
            init_cnt_q <= '0;
`endif
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                addr_q  <= req_addr;
                wr_q    <= req_wr;
                wdata_q <= req_wdata;
            end
            if (state_q == S_ACCESS) begin
                rdata_q <= wr_q ? '0 : mem_rdata;
            end
`ifdef DM_INIT_EN
            if (state_q == S_INIT) begin
                init_cnt_q <= init_cnt_q + ADDRESS_WIDTH'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a 16x1 behavioural data memory.
// Honors DM_INIT_EN the same way the design does.
module tb_dm_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          seed;
    logic [DW-1:0] mem [16];

    int vectors = 0;
    int miscompares = 0;

    dm_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data_memory; seed fills it with ones to stand in for unknown contents.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (seed) begin
            for (int k = 0; k < 16; k++) mem[k] <= '1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction; rsp_ready is held low for `hold` RESP cycles, optionally
    // presenting a conflicting store meanwhile that must be ignored.
    task automatic xact(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                        input int hold, input bit poke, output logic [DW-1:0] rd);
        int n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_wait: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = d; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        vectors++;
        if ({mem_wr, mem_addr, mem_wdata, rsp_valid, req_ready, busy} !==
            {wr, addr, (wr ? d : 1'b0), 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL access_phase a=%0d: got wr=%b addr=%0d wd=%b rv=%b rr=%b busy=%b want wr=%b addr=%0d",
                     addr, mem_wr, mem_addr, mem_wdata, rsp_valid, req_ready, busy, wr, addr);
        end
        tick();
        rd = rsp_rdata;
        vectors++;
        if ({rsp_valid, req_ready, busy, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL resp_phase a=%0d: got rv=%b rr=%b busy=%b mwr=%b maddr=%0d want rv=1 rr=0 busy=1 mwr=0 maddr=0",
                     addr, rsp_valid, req_ready, busy, mem_wr, mem_addr);
        end
        if (wr) begin
            vectors++;
            if (rsp_rdata !== '0) begin
                miscompares++;
                $display("FAIL store_rdata a=%0d: got %b want 0", addr, rsp_rdata);
            end
        end
        if (poke) begin
            req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = ~rd;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            vectors++;
            if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, rd}) begin
                miscompares++;
                $display("FAIL resp_hold cyc=%0d: got rv=%b rr=%b rd=%b want rv=1 rr=0 rd=%b",
                         i, rsp_valid, req_ready, rsp_rdata, rd);
            end
        end
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_rdata, busy, req_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL after_handshake: got rv=%b rd=%b busy=%b rr=%b want 0 0 0 1",
                     rsp_valid, rsp_rdata, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] rd;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        seed = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({rsp_valid, rsp_rdata, mem_wr, mem_addr, mem_wdata} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rv=%b rd=%b mwr=%b maddr=%0d mwd=%b want all 0",
                     rsp_valid, rsp_rdata, mem_wr, mem_addr, mem_wdata);
        end
        seed = 1'b0;
        rst_n = 1'b1;
`ifdef DM_INIT_EN
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({busy, req_ready, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 4'(i), 1'b0}) begin
                miscompares++;
                $display("FAIL init_walk cyc=%0d: got busy=%b rr=%b mwr=%b maddr=%0d mwd=%b want 1 0 1 %0d 0",
                         i, busy, req_ready, mem_wr, mem_addr, mem_wdata, i);
            end
            tick();
        end
        vectors++;
        if ({busy, req_ready, mem_wr} !== 3'b010) begin
            miscompares++;
            $display("FAIL init_done: got busy=%b rr=%b mwr=%b want 0 1 0", busy, req_ready, mem_wr);
        end
        for (int a = 0; a < 16; a++) begin
            xact(1'b0, 4'(a), 1'b0, 0, 1'b0, rd);
            vectors++;
            if (rd !== 1'b0) begin
                miscompares++;
                $display("FAIL init_zero a=%0d: got %b want 0", a, rd);
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({busy, req_ready, mem_wr, rsp_valid} !== 4'b0100) begin
                miscompares++;
                $display("FAIL idle_after_reset cyc=%0d: got busy=%b rr=%b mwr=%b rv=%b want 0 1 0 0",
                         i, busy, req_ready, mem_wr, rsp_valid);
            end
            tick();
        end
`endif
    endtask

    task automatic test_store_load();
        logic [DW-1:0] rd;
        xact(1'b1, 4'd5, 1'b0, 0, 1'b0, rd);
        xact(1'b0, 4'd5, 1'b0, 0, 1'b0, rd);
        vectors++;
        if (rd !== 1'b0) begin
            miscompares++;
            $display("FAIL load5_after_store0: got %b want 0", rd);
        end
        xact(1'b1, 4'd5, 1'b1, 0, 1'b0, rd);
        xact(1'b0, 4'd5, 1'b0, 0, 1'b0, rd);
        vectors++;
        if (rd !== 1'b1) begin
            miscompares++;
            $display("FAIL load5_after_store1: got %b want 1", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] rd;
        xact(1'b1, 4'd3, 1'b1, 0, 1'b0, rd);
        xact(1'b0, 4'd3, 1'b0, 4, 1'b1, rd);
        vectors++;
        if (rd !== 1'b1) begin
            miscompares++;
            $display("FAIL held_load3: got %b want 1", rd);
        end
        xact(1'b0, 4'd3, 1'b0, 0, 1'b0, rd);
        vectors++;
        if (rd !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_req_store3: got %b want 1", rd);
        end
    endtask

    task automatic test_addr_boundary();
        logic [DW-1:0] rd;
        xact(1'b1, 4'd0, 1'b1, 0, 1'b0, rd);
        xact(1'b1, 4'd15, 1'b0, 0, 1'b0, rd);
        xact(1'b0, 4'd0, 1'b0, 0, 1'b0, rd);
        vectors++;
        if (rd !== 1'b1) begin
            miscompares++;
            $display("FAIL addr0_after_store15_0: got %b want 1", rd);
        end
        xact(1'b1, 4'd0, 1'b0, 0, 1'b0, rd);
        xact(1'b1, 4'd15, 1'b1, 0, 1'b0, rd);
        xact(1'b0, 4'd0, 1'b0, 0, 1'b0, rd);
        vectors++;
        if (rd !== 1'b0) begin
            miscompares++;
            $display("FAIL addr0_after_store15_1: got %b want 0", rd);
        end
        xact(1'b0, 4'd15, 1'b0, 0, 1'b0, rd);
        vectors++;
        if (rd !== 1'b1) begin
            miscompares++;
            $display("FAIL load15: got %b want 1", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd;
        logic [3:0]    a;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            xact(1'b1, a, a[0] ^ a[2], 0, 1'b0, rd);
        end
        for (int i = 15; i >= 0; i--) begin
            a = 4'(i);
            xact(1'b0, a, 1'b0, 0, 1'b0, rd);
            vectors++;
            if (rd !== (a[0] ^ a[2])) begin
                miscompares++;
                $display("FAIL pattern_load a=%0d: got %b want %b", i, rd, a[0] ^ a[2]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [DW-1:0] rd;
        int            n = 0;
        xact(1'b1, 4'd7, 1'b0, 0, 1'b0, rd);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd7; req_wdata = 1'b1;
        tick();
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        vectors++;
        if (mem_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_access_entry: got mwr=%b want 1", mem_wr);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
`ifdef DM_INIT_EN
        if ({mem_wr, rsp_valid, busy, req_ready} !== 4'b0010) begin
`else
        if ({mem_wr, rsp_valid, busy, req_ready} !== 4'b0001) begin
`endif
            miscompares++;
            $display("FAIL abort_reset_now: got mwr=%b rv=%b busy=%b rr=%b",
                     mem_wr, rsp_valid, busy, req_ready);
        end
        tick();
        rst_n = 1'b1;
        while (req_ready !== 1'b1 && n < 40) begin
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_rsp cyc=%0d: got rv=%b want 0", n, rsp_valid);
            end
            tick();
            n++;
        end
        vectors++;
`ifdef DM_INIT_EN
        if (n != 16) begin
`else
        if (n != 0) begin
`endif
            miscompares++;
            $display("FAIL abort_recover_cycles: got %0d", n);
        end
        xact(1'b0, 4'd7, 1'b0, 0, 1'b0, rd);
        vectors++;
        if (rd !== 1'b0) begin
            miscompares++;
            $display("FAIL aborted_store_dropped: got %b want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_addr_boundary();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default `INSTR_WORD_WIDTH, data memory address width.
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH, data memory word width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  core presents a memory request.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_wr  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDRESS_WIDTH  request address.
REQ-009 req_wdata  input  DATA_WIDTH  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  core consumes response.
REQ-012 rsp_rdata  output  DATA_WIDTH  load data; 0 for stores.
REQ-013 busy  output  1  controller not in IDLE.
REQ-014 mem_wr  output  1  write strobe to data_memory.
REQ-015 mem_addr  output  ADDRESS_WIDTH  address to data_memory.
REQ-016 mem_wdata  output  DATA_WIDTH  write data to data_memory.
REQ-017 mem_rdata  input  DATA_WIDTH  combinational read data from data_memory.

Function
REQ-018 FSM states: INIT, IDLE, ACCESS, RESP; state register only, outputs decoded from state and registered request fields.
REQ-019 IDLE: req_ready=1, busy=0; req_valid=1 captures req_wr/req_addr/req_wdata into addr_q/wr_q/wdata_q and moves to ACCESS next edge.
REQ-020 ACCESS (exactly one cycle): mem_addr=addr_q; mem_wr=wr_q; mem_wdata=wdata_q; load captures mem_rdata into rdata_q; store loads rdata_q with 0; go to RESP.
REQ-021 RESP: rsp_valid=1, rsp_rdata=rdata_q; hold until rsp_ready=1, then IDLE on that edge.
REQ-022 Latency: request accepted at edge N; memory write at edge N+1; rsp_valid high from edge N+1 until handshake; minimum 3 cycles per transaction, no pipelining.
REQ-023 req_ready=0 in INIT, ACCESS and RESP; req_valid ignored there; no request is queued.
REQ-024 Outside ACCESS and INIT: mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-025 rsp_valid=0 and rsp_rdata=0 in every state except RESP.
REQ-026 A load following a store to the same address returns the stored value; no forwarding needed, the memory is written before the next ACCESS.
REQ-027 Address is used unmodified; no wrap or range check, all 2**ADDRESS_WIDTH addresses valid.

Reset
REQ-028 rst_n low asynchronously forces state to the reset state (INIT or IDLE per REQ-030/031); addr_q, wdata_q, wr_q, rdata_q and the init counter go to 0.
REQ-029 Reset mid-ACCESS drops mem_wr in the same cycle; an in-flight request is discarded with no response.

Configuration
REQ-030 With DM_INIT_EN defined: reset state is INIT; each cycle INIT drives mem_wr=1, mem_wdata=0, mem_addr=init_cnt and increments init_cnt; after address 2**ADDRESS_WIDTH-1 go to IDLE; INIT lasts exactly 2**ADDRESS_WIDTH cycles with busy=1.
REQ-031 Without DM_INIT_EN: no INIT state and no init counter; reset state is IDLE; memory contents are undefined until written.

Structure
REQ-032 Widths (`INSTR_WORD_WIDTH, `DATA_WIDTH) and the FSM state encodings are defined in the shared definy.v include.
REQ-033 No sub-module; dm_ctrl connects directly to the mem_* ports of data_memory in the enclosing level.

Verification (ADDRESS_WIDTH=4, DATA_WIDTH=1, dm_ctrl + data_memory)
REQ-034 DM_INIT_EN, release rst_n -> busy=1 and req_ready=0 for 16 cycles; then load of every address 0..15 returns 0.
REQ-035 Store addr 5 data 1, then load addr 5 with rsp_ready=1 -> rsp_rdata=1; rsp_valid first seen 1 edge after acceptance.
REQ-036 Load addr 3 with rsp_ready=0 for 4 cycles -> rsp_valid held 4 cycles, req_ready=0, a new req_valid is not accepted, rsp_rdata stable.
REQ-037 Store to addr 15 then load addr 0 -> addr 0 is unchanged; the load returns its previous value.
REQ-038 rst_n asserted during ACCESS of a store -> mem_wr=0 immediately, rsp_valid never asserted, FSM in INIT (or IDLE without DM_INIT_EN).
REQ-039 Without DM_INIT_EN, release rst_n -> req_ready=1 in the first cycle after reset and mem_wr never pulses before a request.
